alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
- Shares the single combinational gateboy ALU (op/X/Y/F in, O/FResult out) between two requesters.
- Requester 0 is the CPU execute stage; requester 1 is the CB-prefix/address-increment path.
- Owns the architectural flag register F (bit3..0 = Z,N,H,C) and feeds it to the ALU as the F operand.
- Updates F per request under a write mask, and returns the result and new flags through a valid/ready response port.

Parameters:
RR_ENABLE, 1, 1 = round-robin between requesters; 0 = fixed priority to requester 0
FLAG_RESET, 4'b0000, value loaded into F on reset

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation pending
req0_ready  output  1  requester 0 operation accepted this cycle
req0_op  input  8  ALU opcode (ALU_* encoding)
req0_x  input  16  first operand
req0_y  input  16  second operand
req0_fmask  input  4  F bits this op may update (Z,N,H,C)
req1_valid, req1_ready, req1_op, req1_x, req1_y, req1_fmask  same as requester 0
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_id  output  1  requester that issued this result
rsp_o  output  16  ALU result
rsp_f  output  4  raw ALU FResult (unmasked)
flags_o  output  4  current F register
f_load  input  1  direct F write (POP AF path)
f_wdata  input  4  F write value

Behaviour:
- Reset (synchronous, active-high) sets:
  - state IDLE
  - F = FLAG_RESET
  - priority pointer = 0
  - rsp_valid = 0; rsp_id/rsp_o/rsp_f = 0
  - latched op/x/y/mask/id = 0
  - reqN_ready = 0
- Reset mid-operation drops the in-flight op; no response is issued.
- FSM IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - reqN_ready = (state==IDLE) & reqN_valid & grant==N. It is combinational, and at most one ready is high per cycle.
  - Grant:
    - If only one requester is valid, it wins.
    - If both are valid and RR_ENABLE=1, the pointer owner wins.
    - If both are valid and RR_ENABLE=0, requester 0 wins.
  - On handshake: latch op, x, y, fmask, id; go EXEC.
  - Without a handshake, stay in IDLE.
- EXEC (one cycle):
  - Drive the ALU with the latched op/x/y and the current F.
  - Register O into rsp_o and FResult into rsp_f.
  - Update F <= (F & ~mask) | (FResult & mask).
  - Set rsp_valid = 1; go RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid & !rsp_ready.
  - On rsp_ready: clear rsp_valid, go IDLE, set pointer = ~rsp_id.
- Latency and throughput:
  - Accept in cycle N gives rsp_valid in cycle N+2.
  - Peak throughput is one op per 3 cycles.
- Requester rule: reqN_valid and payload must stay stable until reqN_ready. Dropping valid early is legal and simply withdraws the request.
- f_load:
  - Accepted in any state, effective next cycle.
  - If it coincides with the EXEC flag update, f_load wins. rsp_f still reports the ALU FResult.
- flags_o always shows the registered F. The ALU sees the pre-update F during EXEC.
- An fmask of 0000 performs the op with F untouched, e.g. RES/SET.
- Arithmetic and width rules are entirely the ALU's. This block does no truncation or extension: all 16 bits pass through.
- An unknown opcode is passed through unchanged; F is updated from whatever FResult the ALU returns.

Decomposition:
- Shared package/include, extending the existing ALU op include:
  - ALU_* opcode constants, reused unchanged.
  - Flag bit index constants FLAG_Z=3, FLAG_N=2, FLAG_H=1, FLAG_C=0.
  - State encoding localparams IDLE/EXEC/RESP.
  - Common fmask constants FMASK_ALL=4'b1111, FMASK_NHC=4'b0111, FMASK_NONE=4'b0000.
- One sub-module, the existing ALU, instantiated once.
- The arbiter is a small internal always block; no separate module.

Test Plan:
1. Reset: assert reset 2 cycles with both req valid -> F=0000, rsp_valid=0, req0_ready=req1_ready=0 during reset. First ready after release goes to req0.
2. Single ADD on req0 with X=0x003A, Y=0x00C6, fmask=1111 -> req0_ready at cycle N; rsp_valid at N+2 with rsp_o=0x0000, rsp_f=1011, rsp_id=0; flags_o=1011 from N+2.
3. Carry chaining: following test 2 (C=1), req1 ADC X=0x0001, Y=0x0001, fmask=1111 -> rsp_o=0x0003, rsp_id=1, flags_o=0000.
4. Mask: F=1000; ADD16 X=0x0FFF, Y=0x0001, fmask=0111 -> rsp_o=0x1000, flags_o=1010 (Z held at 1, H=1, C=0). Repeat with fmask=0000 -> flags_o unchanged.
5. Arbitration: both requesters valid continuously for 4 ops.
   - RR_ENABLE=1 -> grant order 0,1,0,1.
   - RR_ENABLE=0 -> 0,0,0,0.
6. Backpressure and reset:
   - Hold rsp_ready=0 for 5 cycles -> rsp_* stable, no readys asserted; release -> IDLE, next grant next cycle.
   - Assert f_load=1, f_wdata=0101 coincident with EXEC -> flags_o=0101.
   - Assert reset during EXEC -> no rsp_valid, F=FLAG_RESET.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared ALU opcodes, flag indices, scheduler state encoding and flag-mask constants.
package alu_sched_pkg;

  localparam logic [7:0] ALU_ADD   = 8'h00;
  localparam logic [7:0] ALU_ADC   = 8'h01;
  localparam logic [7:0] ALU_SUB   = 8'h02;
  localparam logic [7:0] ALU_SBC   = 8'h03;
  localparam logic [7:0] ALU_AND   = 8'h04;
  localparam logic [7:0] ALU_XOR   = 8'h05;
  localparam logic [7:0] ALU_OR    = 8'h06;
  localparam logic [7:0] ALU_CP    = 8'h07;
  localparam logic [7:0] ALU_INC   = 8'h08;
  localparam logic [7:0] ALU_DEC   = 8'h09;
  localparam logic [7:0] ALU_ADD16 = 8'h10;
  localparam logic [7:0] ALU_INC16 = 8'h11;
  localparam logic [7:0] ALU_RES   = 8'h20;
  localparam logic [7:0] ALU_SET   = 8'h21;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] FMASK_ALL  = 4'b1111;
  localparam logic [3:0] FMASK_NHC  = 4'b0111;
  localparam logic [3:0] FMASK_NONE = 4'b0000;

  typedef logic [3:0] flags_t;

  function automatic flags_t mergeFlags(input flags_t cur, input flags_t res, input flags_t mask);
    return (cur & ~mask) | (res & mask);
  endfunction

endpackage

// File: rtl/alu_sched_alu.sv
// Combinational gateboy ALU: 8-bit ops return {8'h00,result}, 16-bit ops the full word.
// Zero latency; no flow control.
module alu_sched_alu
  import alu_sched_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [3:0]  f,
  output logic [15:0] o,
  output logic [3:0]  fResult
);

  logic        cin;
  logic [7:0]  b;
  logic [7:0]  bits;
  logic [4:0]  nib;
  logic [8:0]  byteRes;
  logic [12:0] low12;
  logic [16:0] word;
  logic [15:0] bitMask;

  always_comb begin
    cin     = 1'b0;
    b       = y[7:0];
    bits    = 8'h00;
    nib     = 5'd0;
    byteRes = 9'd0;
    low12   = {1'b0, x[11:0]} + {1'b0, y[11:0]};
    word    = {1'b0, x} + {1'b0, y};
    bitMask = 16'd1 << y[2:0];
    o       = x;
    fResult = f;
    case (op)
      ALU_ADD, ALU_ADC, ALU_INC: begin
        cin     = (op == ALU_ADC) & f[FLAG_C];
        b       = (op == ALU_INC) ? 8'h01 : y[7:0];
        nib     = {1'b0, x[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
        byteRes = {1'b0, x[7:0]} + {1'b0, b} + {8'b0, cin};
        o       = {8'h00, byteRes[7:0]};
        fResult[FLAG_Z] = (byteRes[7:0] == 8'h00);
        fResult[FLAG_N] = 1'b0;
        fResult[FLAG_H] = nib[4];
        fResult[FLAG_C] = (op == ALU_INC) ? f[FLAG_C] : byteRes[8];
      end
      ALU_SUB, ALU_SBC, ALU_CP, ALU_DEC: begin
        // Bit 4 / bit 8 of the widened difference are the half and full borrows.
        cin     = (op == ALU_SBC) & f[FLAG_C];
        b       = (op == ALU_DEC) ? 8'h01 : y[7:0];
        nib     = {1'b0, x[3:0]} - {1'b0, b[3:0]} - {4'b0, cin};
        byteRes = {1'b0, x[7:0]} - {1'b0, b} - {8'b0, cin};
        o       = (op == ALU_CP) ? x : {8'h00, byteRes[7:0]};
        fResult[FLAG_Z] = (byteRes[7:0] == 8'h00);
        fResult[FLAG_N] = 1'b1;
        fResult[FLAG_H] = nib[4];
        fResult[FLAG_C] = (op == ALU_DEC) ? f[FLAG_C] : byteRes[8];
      end
      ALU_AND, ALU_XOR, ALU_OR: begin
        bits = (op == ALU_AND) ? (x[7:0] & y[7:0]) :
               (op == ALU_XOR) ? (x[7:0] ^ y[7:0]) : (x[7:0] | y[7:0]);
        o    = {8'h00, bits};
        fResult[FLAG_Z] = (bits == 8'h00);
        fResult[FLAG_N] = 1'b0;
        fResult[FLAG_H] = (op == ALU_AND);
        fResult[FLAG_C] = 1'b0;
      end
      ALU_ADD16: begin
        o = word[15:0];
        fResult[FLAG_N] = 1'b0;
        fResult[FLAG_H] = low12[12];
        fResult[FLAG_C] = word[16];
      end
      ALU_INC16: o = x + 16'd1;
      ALU_RES:   o = x & ~bitMask;
      ALU_SET:   o = x | bitMask;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sched.sv
// Arbitrates two requesters onto one ALU and owns flag register F; accept->rsp_valid is 2 cycles.
// Requests are stalled (no ready) outside IDLE; rsp_* is held while rsp_ready is low.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter bit         RR_ENABLE  = 1'b1,
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_op,
  input  logic [15:0] req0_x,
  input  logic [15:0] req0_y,
  input  logic [3:0]  req0_fmask,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_op,
  input  logic [15:0] req1_x,
  input  logic [15:0] req1_y,
  input  logic [3:0]  req1_fmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_o,
  output logic [3:0]  rsp_f,
  output logic [3:0]  flags_o,
  input  logic        f_load,
  input  logic [3:0]  f_wdata
);

  logic [1:0]  state;
  logic        ptr;
  flags_t      fReg;
  logic [7:0]  opQ;
  logic [15:0] xQ;
  logic [15:0] yQ;
  flags_t      maskQ;
  logic        idQ;
  logic        grant1;
  logic        accept;
  logic [15:0] aluO;
  flags_t      aluF;

  always_comb begin
    grant1     = req1_valid & (~req0_valid | (RR_ENABLE & ptr));
    req0_ready = ~reset & (state == IDLE) & req0_valid & ~grant1;
    req1_ready = ~reset & (state == IDLE) & grant1;
    accept     = req0_ready | req1_ready;
  end

  alu_sched_alu uAlu (
    .op      (opQ),
    .x       (xQ),
    .y       (yQ),
    .f       (fReg),
    .o       (aluO),
    .fResult (aluF)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      fReg      <= FLAG_RESET;
      opQ       <= 8'h00;
      xQ        <= 16'h0000;
      yQ        <= 16'h0000;
      maskQ     <= 4'h0;
      idQ       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_o     <= 16'h0000;
      rsp_f     <= 4'h0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          opQ   <= grant1 ? req1_op    : req0_op;
          xQ    <= grant1 ? req1_x     : req0_x;
          yQ    <= grant1 ? req1_y     : req0_y;
          maskQ <= grant1 ? req1_fmask : req0_fmask;
          idQ   <= grant1;
          state <= EXEC;
        end
        EXEC: begin
          rsp_o     <= aluO;
          rsp_f     <= aluF;
          rsp_id    <= idQ;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          ptr       <= ~rsp_id;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A direct load (POP AF) overrides the masked ALU update in the same cycle.
      if (f_load)
        fReg <= f_wdata;
      else if (state == EXEC)
        fReg <= mergeFlags(fReg, aluF, maskQ);
    end
  end

  assign flags_o = fReg;

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: directed cases from the block's behaviour plus randomized traffic.
module tb_alu_sched;
  import alu_sched_pkg::*;

  logic        clk, reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_op, req1_op;
  logic [15:0] req0_x, req0_y, req1_x, req1_y;
  logic [3:0]  req0_fmask, req1_fmask;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_o;
  logic [3:0]  rsp_f, flags_o, f_wdata;
  logic        f_load;

  logic        fp_req0_valid, fp_req0_ready, fp_req1_valid, fp_req1_ready;
  logic        fp_rsp_valid, fp_rsp_ready, fp_rsp_id;
  logic [15:0] fp_rsp_o;
  logic [3:0]  fp_rsp_f, fp_flags_o;

  alu_sched #(.RR_ENABLE(1'b1), .FLAG_RESET(4'b0000)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_x(req0_x), .req0_y(req0_y), .req0_fmask(req0_fmask),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_x(req1_x), .req1_y(req1_y), .req1_fmask(req1_fmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_o(rsp_o), .rsp_f(rsp_f), .flags_o(flags_o),
    .f_load(f_load), .f_wdata(f_wdata)
  );

  alu_sched #(.RR_ENABLE(1'b0), .FLAG_RESET(4'b0000)) dutFp (
    .clk(clk), .reset(reset),
    .req0_valid(fp_req0_valid), .req0_ready(fp_req0_ready), .req0_op(ALU_ADD),
    .req0_x(16'h0001), .req0_y(16'h0002), .req0_fmask(FMASK_NONE),
    .req1_valid(fp_req1_valid), .req1_ready(fp_req1_ready), .req1_op(ALU_SUB),
    .req1_x(16'h0005), .req1_y(16'h0001), .req1_fmask(FMASK_NONE),
    .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready), .rsp_id(fp_rsp_id),
    .rsp_o(fp_rsp_o), .rsp_f(fp_rsp_f), .flags_o(fp_flags_o),
    .f_load(1'b0), .f_wdata(4'h0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        id;
    logic [15:0] o;
    logic [3:0]  f;
    logic [3:0]  fl;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  int          nCmp = 0, nErr = 0, cyc = 0, lastAcc = 0, lastRspHs = 0;
  int unsigned rdyPct = 100;
  logic [3:0]  mF;
  logic        rrNext;
  bit          pv[2], pc[2];
  logic [7:0]  pop[2];
  logic [15:0] px[2], py[2], peo[2];
  logic [3:0]  pm[2], pef[2], pefl[2];
  logic [7:0]  opList[13] = '{ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_XOR, ALU_OR,
                              ALU_CP, ALU_INC, ALU_DEC, ALU_ADD16, ALU_INC16, ALU_RES};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failMsg(input string name);
    nCmp++;
    nErr++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference ALU from the instruction-set flag rules, in plain integer arithmetic.
  function automatic void refAlu(input logic [7:0] op, input logic [15:0] x, input logic [15:0] y,
                                 input logic [3:0] f, output logic [15:0] o, output logic [3:0] fr);
    int a, b, c, r, res;
    a = int'(x[7:0]); b = int'(y[7:0]); c = int'(f[0]);
    o = x; fr = f;
    case (op)
      ALU_ADD, ALU_ADC, ALU_INC: begin
        if (op == ALU_INC) b = 1;
        if (op != ALU_ADC) c = 0;
        r = a + b + c; res = r % 256;
        o = 16'(res);
        fr[3] = (res == 0); fr[2] = 1'b0; fr[1] = ((a % 16) + (b % 16) + c) > 15;
        fr[0] = (op == ALU_INC) ? f[0] : (r > 255);
      end
      ALU_SUB, ALU_SBC, ALU_CP, ALU_DEC: begin
        if (op == ALU_DEC) b = 1;
        if (op != ALU_SBC) c = 0;
        res = (a - b - c + 256) % 256;
        o = (op == ALU_CP) ? x : 16'(res);
        fr[3] = (res == 0); fr[2] = 1'b1; fr[1] = (a % 16) < ((b % 16) + c);
        fr[0] = (op == ALU_DEC) ? f[0] : (a < b + c);
      end
      ALU_AND, ALU_XOR, ALU_OR: begin
        res = (op == ALU_AND) ? (a & b) : (op == ALU_XOR) ? (a ^ b) : (a | b);
        o = 16'(res);
        fr[3] = (res == 0); fr[2] = 1'b0; fr[1] = (op == ALU_AND); fr[0] = 1'b0;
      end
      ALU_ADD16: begin
        r = int'(x) + int'(y);
        o = 16'(r % 65536);
        fr[2] = 1'b0; fr[1] = ((int'(x) % 4096) + (int'(y) % 4096)) > 4095; fr[0] = (r > 65535);
      end
      ALU_INC16: o = 16'((int'(x) + 1) % 65536);
      ALU_RES:   o[y[2:0]] = 1'b0;
      ALU_SET:   o[y[2:0]] = 1'b1;
      default: ;
    endcase
  endfunction

  task automatic driveReqs();
    req0_valid = pv[0]; req0_op = pop[0]; req0_x = px[0]; req0_y = py[0]; req0_fmask = pm[0];
    req1_valid = pv[1]; req1_op = pop[1]; req1_x = px[1]; req1_y = py[1]; req1_fmask = pm[1];
  endtask

  task automatic setReq(input int id, input logic [7:0] op, input logic [15:0] x,
                        input logic [15:0] y, input logic [3:0] m);
    pv[id] = 1'b1; pop[id] = op; px[id] = x; py[id] = y; pm[id] = m; pc[id] = 1'b0;
  endtask

  task automatic setConst(input int id, input logic [15:0] eo, input logic [3:0] ef, input logic [3:0] efl);
    pc[id] = 1'b1; peo[id] = eo; pef[id] = ef; pefl[id] = efl;
  endtask

  task automatic setReqRandom(input int id);
    int k;
    logic [7:0] op;
    k = int'($urandom_range(13, 0));
    op = (k == 13) ? 8'($urandom) : opList[k];
    setReq(id, op, 16'($urandom), 16'($urandom), 4'($urandom));
  endtask

  // spacing: 0 none, 1 back-to-back (3 cycles), 2 one cycle after the last response handshake.
  task automatic waitGrant(input int spacing, input bit noPush, input bit fLoadExec,
                           input logic [3:0] fLoadVal, input bit resetExec);
    int got, expW;
    logic [15:0] o;
    logic [3:0] fr, nf;
    exp_t e;
    got = -1;
    expW = (pv[0] && pv[1]) ? int'(rrNext) : (pv[1] ? 1 : 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        got = req1_ready ? 1 : 0;
        break;
      end
    end
    if (got < 0) begin
      failMsg("grant_timeout");
      return;
    end
    check("single_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
    check("grant_id", got, expW);
    if (spacing == 1) check("accept_spacing", cyc - lastAcc, 3);
    if (spacing == 2) check("grant_after_rsp", cyc, lastRspHs + 1);
    refAlu(pop[got], px[got], py[got], mF, o, fr);
    for (int i = 0; i < 4; i++) nf[i] = pm[got][i] ? fr[i] : mF[i];
    if (fLoadExec) nf = fLoadVal;
    if (pc[got]) begin
      o = peo[got]; fr = pef[got]; nf = pefl[got];
    end
    mF = nf;
    e.id = got[0]; e.o = o; e.f = fr; e.fl = nf; e.acc = cyc;
    if (!noPush) sbq.push_back(e);
    rrNext = ~got[0];
    lastAcc = cyc;
    pv[got] = 1'b0;
    @(posedge clk); #1;
    driveReqs();
    if (fLoadExec) begin
      f_load = 1'b1; f_wdata = fLoadVal;
      @(posedge clk); #1;
      f_load = 1'b0;
    end
    if (resetExec) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      mF = 4'b0000;
      rrNext = 1'b0;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !rsp_valid) done = 1'b1;
    end
    if (!done) failMsg("drain");
    @(posedge clk); #1;
  endtask

  task automatic loadF(input logic [3:0] v);
    f_load = 1'b1; f_wdata = v;
    @(posedge clk); #1;
    f_load = 1'b0;
    @(negedge clk);
    check("f_load_value", flags_o, v);
    mF = v;
    @(posedge clk); #1;
  endtask

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(99, 0) < rdyPct);
    end
  end

  initial begin : monitor
    logic prevV, prevRdy, hId;
    logic [15:0] hO;
    logic [3:0] hF;
    exp_t e;
    prevV = 1'b0; prevRdy = 1'b0; hId = 1'b0; hO = 16'h0; hF = 4'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prevV = 1'b0;
      end else begin
        if (rsp_valid && (req0_ready || req1_ready)) failMsg("ready_during_resp");
        if (rsp_valid && !prevV) begin
          if (sbq.size() == 0) failMsg("unexpected_rsp");
          else check("latency", cyc - sbq[0].acc, 2);
        end
        if (rsp_valid && prevV && !prevRdy) begin
          check("hold_o", rsp_o, hO);
          check("hold_f", rsp_f, hF);
          check("hold_id", rsp_id, hId);
        end
        if (rsp_valid && rsp_ready && sbq.size() > 0) begin
          e = sbq.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_o", rsp_o, e.o);
          check("rsp_f", rsp_f, e.f);
          check("flags_o", flags_o, e.fl);
          lastRspHs = cyc;
        end
        prevV = rsp_valid; prevRdy = rsp_ready;
        hO = rsp_o; hF = rsp_f; hId = rsp_id;
      end
    end
  end

  initial begin : stim
    int n;
    bit seen;
    reset = 1'b1; f_load = 1'b0; f_wdata = 4'h0; mF = 4'b0000; rrNext = 1'b0;
    fp_req0_valid = 1'b0; fp_req1_valid = 1'b0; fp_rsp_ready = 1'b0;
    // Reset with both requesters pending; the ADD then the carry-chained ADC follow.
    setReq(0, ALU_ADD, 16'h003A, 16'h00C6, FMASK_ALL); setConst(0, 16'h0000, 4'b1011, 4'b1011);
    setReq(1, ALU_ADC, 16'h0001, 16'h0001, FMASK_ALL); setConst(1, 16'h0003, 4'b0000, 4'b0000);
    driveReqs();
    repeat (2) begin
      @(negedge clk);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_flags", flags_o, 4'b0000);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    waitGrant(0, 0, 0, 4'h0, 0);
    waitGrant(0, 0, 0, 4'h0, 0);
    drain();

    // Masked updates: Z held by mask 0111, then everything held by mask 0000.
    loadF(4'b1000);
    setReq(0, ALU_ADD16, 16'h0FFF, 16'h0001, FMASK_NHC); setConst(0, 16'h1000, 4'b1010, 4'b1010);
    driveReqs();
    waitGrant(0, 0, 0, 4'h0, 0);
    drain();
    setReq(1, ALU_ADD16, 16'h0FFF, 16'h0001, FMASK_NONE); setConst(1, 16'h1000, 4'b1010, 4'b1010);
    driveReqs();
    waitGrant(0, 0, 0, 4'h0, 0);
    drain();

    // Both requesters continuously valid: alternation at full rate.
    rdyPct = 100;
    for (int k = 0; k < 4; k++) begin
      if (!pv[0]) setReqRandom(0);
      if (!pv[1]) setReqRandom(1);
      driveReqs();
      waitGrant((k > 0) ? 1 : 0, 0, 0, 4'h0, 0);
    end
    waitGrant(1, 0, 0, 4'h0, 0);
    drain();

    // Response backpressure for 5 cycles with the other requester waiting.
    rdyPct = 0;
    setReqRandom(0);
    driveReqs();
    waitGrant(0, 0, 0, 4'h0, 0);
    setReqRandom(1);
    driveReqs();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    if (!seen) failMsg("bp_rsp_valid");
    repeat (5) @(negedge clk);
    rdyPct = 100;
    waitGrant(2, 0, 0, 4'h0, 0);
    drain();

    // f_load coinciding with EXEC beats the ALU flags; rsp_f stays the raw result.
    setReq(0, ALU_SUB, 16'h0010, 16'h0001, FMASK_ALL); setConst(0, 16'h000F, 4'b0110, 4'b0101);
    driveReqs();
    waitGrant(0, 0, 1, 4'b0101, 0);
    drain();
    check("f_load_exec", flags_o, 4'b0101);

    // Reset while an op is in EXEC: no response, F back to its reset value.
    loadF(4'b1111);
    setReqRandom(1);
    driveReqs();
    waitGrant(0, 1, 0, 4'h0, 1);
    @(negedge clk);
    check("rst_exec_flags", flags_o, 4'b0000);
    repeat (4) begin
      check("rst_exec_no_rsp", rsp_valid, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;

    for (int r = 0; r < 150; r++) begin
      if (r % 20 == 0) rdyPct = $urandom_range(100, 30);
      for (int id = 0; id < 2; id++)
        if (!pv[id] && $urandom_range(1, 0) == 1) setReqRandom(id);
      if (!pv[0] && !pv[1]) setReqRandom(int'($urandom_range(1, 0)));
      driveReqs();
      waitGrant(0, 0, 0, 4'h0, 0);
    end
    while (pv[0] || pv[1]) waitGrant(0, 0, 0, 4'h0, 0);
    rdyPct = 100;
    drain();

    // Fixed-priority instance: requester 0 always wins while both are valid.
    fp_rsp_ready = 1'b1; fp_req0_valid = 1'b1; fp_req1_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      check("fp_ready1", fp_req1_ready, 0);
      if (fp_rsp_valid && fp_rsp_ready) begin
        check("fp_grant", fp_rsp_id, 0);
        n++;
      end
    end
    if (n < 4) failMsg("fp_timeout");
    fp_req0_valid = 1'b0; fp_req1_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
